// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: arbitration-mode constants and small helpers shared by the
// shared register arbiter and its combinational grant logic.
package shared_reg_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of an index into n sources. Never zero, so that a single source
    // still gets a 1-bit index port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when two or more bits are set. Clearing the lowest set bit leaves
    // something behind only if a second bit was set.
    function automatic logic popcount_ge2(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational grant selection.
//   req      - per-source request vector
//   pointer  - round-robin search start (ignored in fixed-priority mode)
//   gnt      - one-hot winner, zero when nothing requests
//   gnt_idx  - binary index of the winner
//   any_gnt  - some source was granted
// Round-robin searches upward from pointer with wrap-around; fixed priority
// always searches from index 0. The pointer register lives in the parent.
module rr_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int IDX_W    = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_gnt
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                idx = k;
            end else begin
                // pointer is always < NUM_SRC, so one subtraction wraps it
                idx = int'(pointer) + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            end
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    assign any_gnt = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: single-driver replacement for a register that several
// sources used to assign directly. One writer is granted per cycle and its
// data lands in q at the next edge.
//   clk, rst_n    - clock, asynchronous active-low reset
//   wr_req        - per-source level write request
//   wr_data       - packed per-source data, source i at [i*DATA_W +: DATA_W]
//   clr           - synchronous clear of conflict / conflict_cnt
//   q, q_valid    - shared register and "written since reset" flag
//   wr_gnt        - one-hot writer of the last edge, zero if no write
//   last_src      - index of the most recent writer (holds between writes)
//   conflict      - pulse: two or more requests in the previous cycle
//   conflict_cnt  - saturating conflict count
// Optional feature macro SHARED_REG_CONFLICT_CNT_EN: when undefined there is
// no counter and conflict_cnt reads 0; the conflict pulse is always present.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int                NUM_SRC   = 2,
    parameter int                DATA_W    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                ARB_MODE  = ARB_RR,
    parameter int                CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             wr_req,
    input  logic [NUM_SRC*DATA_W-1:0]      wr_data,
    input  logic                           clr,
    output logic [DATA_W-1:0]              q,
    output logic                           q_valid,
    output logic [NUM_SRC-1:0]             wr_gnt,
    output logic [clog2_min1(NUM_SRC)-1:0] last_src,
    output logic                           conflict,
    output logic [CNT_W-1:0]               conflict_cnt
);

    localparam int IDX_W = clog2_min1(NUM_SRC);

    logic [IDX_W-1:0]   pointer;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_SRC-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic               conflict_now;

    rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ARB_MODE (ARB_MODE),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req     (wr_req),
        .pointer (pointer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // A single source can never collide; the helper returns 0 for it anyway.
    assign conflict_now = popcount_ge2(16'(wr_req));

    assign ptr_next = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= RESET_VAL;
            q_valid  <= 1'b0;
            wr_gnt   <= '0;
            last_src <= '0;
            pointer  <= '0;
            conflict <= 1'b0;
        end else begin
            wr_gnt <= gnt;
            if (any_gnt) begin
                q        <= wr_data[gnt_idx*DATA_W +: DATA_W];
                q_valid  <= 1'b1;
                last_src <= gnt_idx;
            end
            // Fixed priority never moves the pointer, so it stays at 0.
            if (ARB_MODE == ARB_RR && any_gnt) pointer <= ptr_next;
            // clr wins over a simultaneous conflict.
            conflict <= clr ? 1'b0 : conflict_now;
        end
    end

`ifdef SHARED_REG_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (conflict_now && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = cnt;
`else
    assign conflict_cnt = '0;
`endif

endmodule
